// File: rtl/issue_queue_cdb_pkg.sv
// Shared widths and the packed entry layout for the CDB-snooping issue queue.
// Module widths default to these constants; the typedef matches the default sizing.
package issue_queue_cdb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int TAG_W_DEF  = 6;
  localparam int CTRL_W_DEF = 45;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [XLEN_DEF-1:0]   rs1_data;
    logic                  rs1_vld;
    logic [TAG_W_DEF-1:0]  rs1_tag;
    logic [XLEN_DEF-1:0]   rs2_data;
    logic                  rs2_vld;
    logic [TAG_W_DEF-1:0]  rs2_tag;
  } iq_entry_t;

endpackage

// File: rtl/iq_entry.sv
// One queue slot: stores an instruction and snoops the CDB for missing operands.
// Write and capture land at the next edge; flush clears operand valids and drops the write.
module iq_entry
  import issue_queue_cdb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              occupied_i,
  input  logic              wr_en_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic              rs1_vld_i,
  input  logic [TAG_W-1:0]  rs1_tag_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              rs2_vld_i,
  input  logic [TAG_W-1:0]  rs2_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [XLEN-1:0]   cdb_data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic              rs1_vld_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              rs2_vld_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic              rs1_vld;
    logic [TAG_W-1:0]  rs1_tag;
    logic [XLEN-1:0]   rs2_data;
    logic              rs2_vld;
    logic [TAG_W-1:0]  rs2_tag;
  } slot_t;

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (wr_en_i) begin
      slot_d.ctrl     = ctrl_i;
      slot_d.rs1_data = rs1_data_i;
      slot_d.rs1_vld  = rs1_vld_i;
      slot_d.rs1_tag  = rs1_tag_i;
      slot_d.rs2_data = rs2_data_i;
      slot_d.rs2_vld  = rs2_vld_i;
      slot_d.rs2_tag  = rs2_tag_i;
      // Broadcast in the push cycle would otherwise be missed forever.
      if (cdb_valid_i && !rs1_vld_i && (rs1_tag_i == cdb_tag_i)) begin
        slot_d.rs1_data = cdb_data_i;
        slot_d.rs1_vld  = 1'b1;
      end
      if (cdb_valid_i && !rs2_vld_i && (rs2_tag_i == cdb_tag_i)) begin
        slot_d.rs2_data = cdb_data_i;
        slot_d.rs2_vld  = 1'b1;
      end
    end else if (occupied_i && cdb_valid_i) begin
      if (!slot_q.rs1_vld && (slot_q.rs1_tag == cdb_tag_i)) begin
        slot_d.rs1_data = cdb_data_i;
        slot_d.rs1_vld  = 1'b1;
      end
      if (!slot_q.rs2_vld && (slot_q.rs2_tag == cdb_tag_i)) begin
        slot_d.rs2_data = cdb_data_i;
        slot_d.rs2_vld  = 1'b1;
      end
    end
    if (flush_i) begin
      slot_d         = slot_q;
      slot_d.rs1_vld = 1'b0;
      slot_d.rs2_vld = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign ctrl_o     = slot_q.ctrl;
  assign rs1_data_o = slot_q.rs1_data;
  assign rs1_vld_o  = slot_q.rs1_vld;
  assign rs2_data_o = slot_q.rs2_data;
  assign rs2_vld_o  = slot_q.rs2_vld;

endmodule

// File: rtl/issue_queue_cdb.sv
// In-order issue queue whose entries wake up from CDB broadcasts; head issues when both operands valid.
// Head visible combinationally; push refused when full, no pass-through; wake-up seen one cycle after broadcast.
module issue_queue_cdb
  import issue_queue_cdb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = XLEN_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [CTRL_W-1:0]          i_ctrl,
  input  logic [XLEN-1:0]            i_rs1_data,
  input  logic [XLEN-1:0]            i_rs2_data,
  input  logic                       i_rs1_vld,
  input  logic                       i_rs2_vld,
  input  logic [TAG_W-1:0]           i_rs1_tag,
  input  logic [TAG_W-1:0]           i_rs2_tag,
  input  logic                       i_cdb_valid,
  input  logic [TAG_W-1:0]           i_cdb_tag,
  input  logic [XLEN-1:0]            i_cdb_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [CTRL_W-1:0]          o_ctrl,
  output logic [XLEN-1:0]            o_rs1_data,
  output logic [XLEN-1:0]            o_rs2_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx;
  logic             full, empty, push, pop;

  logic [CTRL_W-1:0] e_ctrl     [DEPTH];
  logic [XLEN-1:0]   e_rs1_data [DEPTH];
  logic [XLEN-1:0]   e_rs2_data [DEPTH];
  logic              e_rs1_vld  [DEPTH];
  logic              e_rs2_vld  [DEPTH];

  assign head_idx = rp_q[IDX_W-1:0];
  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[IDX_W-1:0] == rp_q[IDX_W-1:0]) && (wp_q[IDX_W] != rp_q[IDX_W]);
  assign count    = wp_q - rp_q;

  assign o_in_ready  = !full && !i_rst;
  assign o_out_valid = !empty && !i_rst && e_rs1_vld[head_idx] && e_rs2_vld[head_idx];
  assign push        = i_in_valid && o_in_ready;
  assign pop         = o_out_valid && i_out_ready;

  assign o_count    = count;
  assign o_empty    = empty;
  assign o_ctrl     = o_out_valid ? e_ctrl[head_idx]     : '0;
  assign o_rs1_data = o_out_valid ? e_rs1_data[head_idx] : '0;
  assign o_rs2_data = o_out_valid ? e_rs2_data[head_idx] : '0;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (i_flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam logic [IDX_W-1:0] SLOT = IDX_W'(g);
    logic [IDX_W-1:0] offs;
    logic             occupied;
    logic             wr_en;

    // Slot is live when its distance from the head is below the occupancy.
    assign offs     = SLOT - head_idx;
    assign occupied = ({1'b0, offs} < count);
    assign wr_en    = push && (wp_q[IDX_W-1:0] == SLOT);

    iq_entry #(
      .XLEN   (XLEN),
      .TAG_W  (TAG_W),
      .CTRL_W (CTRL_W)
    ) u_entry (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .flush_i     (i_flush),
      .occupied_i  (occupied),
      .wr_en_i     (wr_en),
      .ctrl_i      (i_ctrl),
      .rs1_data_i  (i_rs1_data),
      .rs1_vld_i   (i_rs1_vld),
      .rs1_tag_i   (i_rs1_tag),
      .rs2_data_i  (i_rs2_data),
      .rs2_vld_i   (i_rs2_vld),
      .rs2_tag_i   (i_rs2_tag),
      .cdb_valid_i (i_cdb_valid),
      .cdb_tag_i   (i_cdb_tag),
      .cdb_data_i  (i_cdb_data),
      .ctrl_o      (e_ctrl[g]),
      .rs1_data_o  (e_rs1_data[g]),
      .rs1_vld_o   (e_rs1_vld[g]),
      .rs2_data_o  (e_rs2_data[g]),
      .rs2_vld_o   (e_rs2_vld[g])
    );
  end

endmodule

// File: tb/tb_issue_queue_cdb.sv
// Directed bench for issue_queue_cdb at default sizing (DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_issue_queue_cdb;
  import issue_queue_cdb_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_rst, i_flush, i_in_valid, i_cdb_valid, i_out_ready;
  logic [CTRL_W_DEF-1:0] i_ctrl;
  logic [XLEN_DEF-1:0]   i_rs1_data, i_rs2_data, i_cdb_data;
  logic                  i_rs1_vld, i_rs2_vld;
  logic [TAG_W_DEF-1:0]  i_rs1_tag, i_rs2_tag, i_cdb_tag;
  logic                  o_in_ready, o_out_valid, o_empty;
  logic [CTRL_W_DEF-1:0] o_ctrl;
  logic [XLEN_DEF-1:0]   o_rs1_data, o_rs2_data;
  logic [2:0]            o_count;

  iq_entry_t pe;
  int n_checks = 0;
  int n_err    = 0;

  issue_queue_cdb dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_ctrl(i_ctrl), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_rs1_vld(i_rs1_vld), .i_rs2_vld(i_rs2_vld),
    .i_rs1_tag(i_rs1_tag), .i_rs2_tag(i_rs2_tag),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_ctrl(o_ctrl), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_push(input logic vld);
    i_in_valid = vld;
    i_ctrl     = pe.ctrl;
    i_rs1_data = pe.rs1_data;
    i_rs1_vld  = pe.rs1_vld;
    i_rs1_tag  = pe.rs1_tag;
    i_rs2_data = pe.rs2_data;
    i_rs2_vld  = pe.rs2_vld;
    i_rs2_tag  = pe.rs2_tag;
  endtask

  task automatic set_full_valid(input int c);
    pe = '0;
    pe.ctrl     = CTRL_W_DEF'(c);
    pe.rs1_data = XLEN_DEF'(c * 16 + 1);
    pe.rs2_data = XLEN_DEF'(c * 16 + 2);
    pe.rs1_vld  = 1'b1;
    pe.rs2_vld  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  64'(o_in_ready),  64'd0);
    check_eq({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
    check_eq({tag, "_count"},     64'(o_count),     64'd0);
    check_eq({tag, "_empty"},     64'(o_empty),     64'd1);
    check_eq({tag, "_ctrl"},      64'(o_ctrl),      64'd0);
    check_eq({tag, "_rs1"},       64'(o_rs1_data),  64'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_cdb_valid = 1'b0; i_out_ready = 1'b0;
    i_cdb_tag = '0; i_cdb_data = '0;
    pe = '0;
    drive_push(1'b0);
    #3;
    check_reset_outputs("rst");
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    check_eq("rdy_after_rst", 64'(o_in_ready), 64'd1);

    // Fill to capacity, then an ignored fifth push.
    for (int k = 0; k < 4; k++) begin
      set_full_valid(100 + k);
      drive_push(1'b1);
      tick();
    end
    set_full_valid(999);
    drive_push(1'b1);
    check_eq("full_ready", 64'(o_in_ready), 64'd0);
    check_eq("full_count", 64'(o_count), 64'd4);
    tick();
    check_eq("ovf_count", 64'(o_count), 64'd4);
    check_eq("ovf_head", 64'(o_ctrl), 64'd100);

    // Push+pop while full: pop only.
    i_out_ready = 1'b1;
    tick();
    drive_push(1'b0);
    check_eq("fullpp_count", 64'(o_count), 64'd3);
    for (int k = 1; k < 4; k++) begin
      check_eq($sformatf("drain_ctrl%0d", k), 64'(o_ctrl), 64'(100 + k));
      check_eq($sformatf("drain_rs2_%0d", k), 64'(o_rs2_data), 64'((100 + k) * 16 + 2));
      tick();
    end
    i_out_ready = 1'b0;
    check_eq("drain_empty", 64'(o_empty), 64'd1);
    check_eq("drain_ovalid", 64'(o_out_valid), 64'd0);
    check_eq("drain_ctrl0", 64'(o_ctrl), 64'd0);

    // Wake-up of the head; the tag-6 entry behind must stay waiting.
    pe = '0; pe.ctrl = 'h11; pe.rs1_tag = 5; pe.rs2_vld = 1'b1; pe.rs2_data = 'h55;
    drive_push(1'b1);
    tick();
    pe = '0; pe.ctrl = 'h22; pe.rs1_tag = 6; pe.rs1_data = 'hAAAA; pe.rs2_vld = 1'b1;
    drive_push(1'b1);
    tick();
    drive_push(1'b0);
    check_eq("wk_pre_valid", 64'(o_out_valid), 64'd0);
    i_cdb_valid = 1'b1; i_cdb_tag = 5; i_cdb_data = 32'hDEADBEEF;
    #2;
    check_eq("wk_bcast_cycle", 64'(o_out_valid), 64'd0);
    tick();
    i_cdb_valid = 1'b0;
    check_eq("wk_valid", 64'(o_out_valid), 64'd1);
    check_eq("wk_rs1", 64'(o_rs1_data), 64'hDEADBEEF);
    check_eq("wk_ctrl", 64'(o_ctrl), 64'h11);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check_eq("wk_tag6_wait", 64'(o_out_valid), 64'd0);
    check_eq("wk_count", 64'(o_count), 64'd1);
    i_cdb_valid = 1'b1; i_cdb_tag = 6; i_cdb_data = 32'h66;
    tick();
    i_cdb_valid = 1'b0;
    check_eq("wk6_valid", 64'(o_out_valid), 64'd1);
    check_eq("wk6_rs1", 64'(o_rs1_data), 64'h66);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;

    // Push-cycle bypass from the CDB.
    pe = '0; pe.ctrl = 'h33; pe.rs1_vld = 1'b1; pe.rs1_data = 'h77;
    pe.rs2_tag = 9; pe.rs2_data = 'h5555;
    drive_push(1'b1);
    i_cdb_valid = 1'b1; i_cdb_tag = 9; i_cdb_data = 32'h1234;
    tick();
    drive_push(1'b0);
    i_cdb_valid = 1'b0;
    check_eq("byp_valid", 64'(o_out_valid), 64'd1);
    check_eq("byp_rs2", 64'(o_rs2_data), 64'h1234);
    check_eq("byp_rs1", 64'(o_rs1_data), 64'h77);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;

    // Steady push+pop at count 2 across pointer wrap.
    for (int k = 0; k < 2; k++) begin
      set_full_valid(200 + k);
      drive_push(1'b1);
      tick();
    end
    i_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_full_valid(202 + k);
      drive_push(1'b1);
      check_eq($sformatf("wrap_head%0d", k), 64'(o_ctrl), 64'(200 + k));
      tick();
      check_eq($sformatf("wrap_count%0d", k), 64'(o_count), 64'd2);
    end
    drive_push(1'b0);
    tick();
    tick();
    i_out_ready = 1'b0;
    check_eq("wrap_empty", 64'(o_empty), 64'd1);

    // Flush with three entries, plus a push that must be dropped.
    for (int k = 0; k < 3; k++) begin
      set_full_valid(300 + k);
      drive_push(1'b1);
      tick();
    end
    check_eq("fl_pre_count", 64'(o_count), 64'd3);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive_push(1'b0);
    check_eq("fl_empty", 64'(o_empty), 64'd1);
    check_eq("fl_count", 64'(o_count), 64'd0);
    check_eq("fl_ovalid", 64'(o_out_valid), 64'd0);

    // Asynchronous reset in the middle of a push burst.
    for (int k = 0; k < 2; k++) begin
      set_full_valid(400 + k);
      drive_push(1'b1);
      tick();
    end
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    tick();
    drive_push(1'b0);
    i_rst = 1'b0;
    #1;
    check_eq("arst_rel_ready", 64'(o_in_ready), 64'd1);
    check_eq("arst_rel_count", 64'(o_count), 64'd0);
    pe = '0; pe.ctrl = 'h44; pe.rs1_tag = 3; pe.rs2_vld = 1'b1;
    drive_push(1'b1);
    tick();
    drive_push(1'b0);
    check_eq("arst_stale_vld", 64'(o_out_valid), 64'd0);
    check_eq("arst_new_count", 64'(o_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_cdb.md
ISSUE_QUEUE_CDB -- requirements
Module: issue_queue_cdb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning entry count (power of two, 2..32).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning operand data width.
REQ-003 The block SHALL have parameter TAG_W, default 6, meaning producer tag width.
REQ-004 The block SHALL have parameter CTRL_W, default 45, meaning opaque control payload width.
REQ-005 Ports SHALL be:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_flush  in  1  synchronous clear.
- i_in_valid  in  1  push request.
- o_in_ready  out  1  queue can accept.
- i_ctrl  in  CTRL_W  control payload.
- i_rs1_data / i_rs2_data  in  XLEN  operand values.
- i_rs1_vld / i_rs2_vld  in  1  operand value already valid.
- i_rs1_tag / i_rs2_tag  in  TAG_W  producer tag for an invalid operand.
- i_cdb_valid  in  1  CDB broadcast valid.
- i_cdb_tag  in  TAG_W  CDB tag.
- i_cdb_data  in  XLEN  CDB value.
- o_out_valid  out  1  head entry present with both operands valid.
- i_out_ready  in  1  consumer takes head.
- o_ctrl, o_rs1_data, o_rs2_data  out  as inputs  head entry fields.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_empty  out  1  count==0.

Function
REQ-006 Storage SHALL be an in-order circular buffer with read/write pointers one bit wider than the index; full = index bits equal and wrap bits differ; empty = pointers equal.
REQ-007 o_in_ready SHALL equal !full; a push occurs when i_in_valid && o_in_ready, writing at wp and incrementing wp modulo 2*DEPTH.
REQ-008 A pop SHALL occur when o_out_valid && i_out_ready, incrementing rp modulo 2*DEPTH.
REQ-009 Push and pop in the same cycle SHALL both take effect, leaving o_count unchanged; push while full SHALL be ignored, with no pass-through.
REQ-010 o_out_valid SHALL be !empty && head rs1_vld && head rs2_vld, computed from stored state only.
REQ-011 On i_cdb_valid, every occupied entry whose rsX_vld==0 and rsX_tag==i_cdb_tag SHALL capture i_cdb_data into rsX_data and set rsX_vld=1 at the clock edge; rs1 and rs2 are handled independently.
REQ-012 A pushed operand with vld==0 whose tag matches a valid CDB in the same cycle SHALL be written already valid with i_cdb_data.
REQ-013 A CDB wake-up of the head SHALL raise o_out_valid exactly one cycle after the broadcast cycle.
REQ-014 Unoccupied entries SHALL ignore CDB broadcasts.
REQ-015 o_ctrl, o_rs1_data and o_rs2_data SHALL present head fields combinationally and SHALL be zero when o_out_valid==0.
REQ-016 i_flush SHALL, at the clock edge, zero both pointers, clear every entry's valid bits, and discard any same-cycle push, pop or CDB capture.
REQ-017 o_count SHALL equal wp-rp modulo 2*DEPTH and SHALL never exceed DEPTH.

Reset
REQ-018 While i_rst is high, the block SHALL hold pointers at 0, all operand valid bits at 0, o_in_ready=0, o_out_valid=0, o_count=0, o_empty=1 and data outputs at 0.
REQ-019 Reset assertion SHALL take effect immediately, asynchronous to i_clk; after deassertion, o_in_ready SHALL be 1 on the first cycle.
REQ-020 Assertion of i_rst mid-operation SHALL discard all contents, with no partial-state retention.

Structure
REQ-021 A shared package SHALL hold default XLEN and TAG_W constants and a packed entry typedef {ctrl, rs1_data, rs1_vld, rs1_tag, rs2_data, rs2_vld, rs2_tag}.
REQ-022 The per-entry storage and CDB snoop logic SHALL be a sub-module, iq_entry, instantiated DEPTH times by generate; pointer, count and handshake logic SHALL stay in the top level.

Verification
REQ-023 Fill/drain: with DEPTH=4, push 4 fully valid entries, then o_in_ready=0 and o_count=4; a 5th push is ignored; popping 4 times returns payloads in order and ends with o_empty=1.
REQ-024 Wake-up: push head with rs1_vld=0, rs1_tag=5; CDB tag=5, data=0xDEADBEEF -> o_out_valid=1 the next cycle, o_rs1_data=0xDEADBEEF; an entry holding tag 6 stays unchanged.
REQ-025 Write bypass: push rs2_vld=0, tag=9 in the same cycle as CDB tag=9, data=0x1234 -> entry stored valid, o_out_valid=1 the next cycle, o_rs2_data=0x1234.
REQ-026 Simultaneous: queue full, push and pop in the same cycle -> push rejected and pop taken, o_count=3; then push and pop with count 2 -> count stays 2 across 8 cycles of pointer wrap.
REQ-027 Flush/reset: with 3 entries, i_flush -> o_empty=1 and o_count=0 next cycle; assert i_rst asynchronously mid-burst -> outputs match REQ-018 before the next edge.
